// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 read port between icache, dcache and uncached requesters.
// One burst in flight at a time; fixed priority dcache > uncache > icache.
module axi_rd_arbiter #(
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic                      icache_ren,
    input  logic [31:0]               icache_raddr,
    output logic [32*LINE_WORDS-1:0]  icache_line,
    output logic                      icache_refresh,

    input  logic                      dcache_ren,
    input  logic [31:0]               dcache_raddr,
    output logic [32*LINE_WORDS-1:0]  dcache_line,
    output logic                      dcache_refresh,

    input  logic                      uc_ren,
    input  logic [31:0]               uc_raddr,
    output logic [31:0]               uc_rdata,
    output logic                      uc_refresh,

    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [3:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,

    input  logic [3:0]                rid,
    input  logic [31:0]               rdata,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int unsigned CntW  = $clog2(LINE_WORDS);
    localparam int unsigned Off   = CntW + 2;
    localparam int unsigned LineW = 32 * LINE_WORDS;

    // Grant encoding doubles as the AXI id.
    localparam logic [1:0] GntI = 2'd0;
    localparam logic [1:0] GntD = 2'd1;
    localparam logic [1:0] GntU = 2'd2;

    typedef enum logic [1:0] {StIdle, StAr, StR, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LineW-1:0]  iline_q, iline_d;
    logic [LineW-1:0]  dline_q, dline_d;
    logic [31:0]       udata_q, udata_d;

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return {a[31:Off], {Off{1'b0}}};
    endfunction

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        iline_d = iline_q;
        dline_d = dline_q;
        udata_d = udata_q;
        case (state_q)
            StIdle: begin
                if (dcache_ren) begin
                    gnt_d  = GntD;
                    addr_d = line_base(dcache_raddr);
                    len_d  = 4'(LINE_WORDS - 1);
                end else if (uc_ren) begin
                    gnt_d  = GntU;
                    addr_d = uc_raddr;
                    len_d  = 4'd0;
                end else if (icache_ren) begin
                    gnt_d  = GntI;
                    addr_d = line_base(icache_raddr);
                    len_d  = 4'(LINE_WORDS - 1);
                end
                if (dcache_ren || uc_ren || icache_ren) begin
                    cnt_d   = '0;
                    state_d = StAr;
                end
            end
            StAr: begin
                if (arready) state_d = StR;
            end
            StR: begin
                if (rvalid) begin
                    // Counter wraps naturally; rlast alone terminates the burst.
                    cnt_d = cnt_q + 1'b1;
                    for (int i = 0; i < LINE_WORDS; i++) begin
                        if (cnt_q == CntW'(i)) begin
                            if (gnt_q == GntI) iline_d[32*i +: 32] = rdata;
                            if (gnt_q == GntD) dline_d[32*i +: 32] = rdata;
                        end
                    end
                    if (gnt_q == GntU) udata_d = rdata;
                    if (rlast) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            gnt_q   <= GntI;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            iline_q <= '0;
            dline_q <= '0;
            udata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            iline_q <= iline_d;
            dline_q <= dline_d;
            udata_q <= udata_d;
        end
    end

    assign arvalid = (state_q == StAr);
    assign rready  = (state_q == StR);
    assign araddr  = addr_q;
    assign arid    = {2'b00, gnt_q};
    assign arlen   = len_q;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign icache_refresh = (state_q == StDone) && (gnt_q == GntI);
    assign dcache_refresh = (state_q == StDone) && (gnt_q == GntD);
    assign uc_refresh     = (state_q == StDone) && (gnt_q == GntU);

    assign icache_line = iline_q;
    assign dcache_line = dline_q;
    assign uc_rdata    = udata_q;

    // Response id is deliberately ignored.
    logic unused_rid;
    assign unused_rid = ^rid;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised scoreboard bench for axi_rd_arbiter: expected grants come from a
// priority model, expected line contents from the beats the bench's AXI slave sends.
module tb_axi_rd_arbiter;

    localparam int LW = 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          icache_ren, dcache_ren, uc_ren;
    logic [31:0]   icache_raddr, dcache_raddr, uc_raddr;
    logic [32*LW-1:0] icache_line, dcache_line;
    logic [31:0]   uc_rdata;
    logic          icache_refresh, dcache_refresh, uc_refresh;
    logic [3:0]    arid, arlen;
    logic [31:0]   araddr;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid, arready;
    logic [3:0]    rid;
    logic [31:0]   rdata;
    logic          rlast, rvalid, rready;

    axi_rd_arbiter #(.LINE_WORDS(LW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .icache_ren(icache_ren), .icache_raddr(icache_raddr),
        .icache_line(icache_line), .icache_refresh(icache_refresh),
        .dcache_ren(dcache_ren), .dcache_raddr(dcache_raddr),
        .dcache_line(dcache_line), .dcache_refresh(dcache_refresh),
        .uc_ren(uc_ren), .uc_raddr(uc_raddr), .uc_rdata(uc_rdata), .uc_refresh(uc_refresh),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct packed { logic [1:0] id; logic [31:0] addr; logic [3:0] len; } ar_t;
    typedef struct packed { logic [1:0] id; int cyc; } ref_t;

    ar_t  exp_ar[$];
    ref_t exp_ref[$];
    logic [31:0] m_line[2][LW];   // [0] icache, [1] dcache
    logic [31:0] m_u;

    int n_pass = 0;
    int n_total = 0;
    bit seq_data = 0;
    int ar_wait_fix = -1;
    int sl_ph = 0;
    int sl_beat = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [255:0] model_line(input int id);
        logic [255:0] v;
        for (int w = 0; w < LW; w++) v[32*w +: 32] = m_line[id][w];
        return v;
    endfunction

    task automatic clear_model();
        for (int w = 0; w < LW; w++) begin
            m_line[0][w] = '0;
            m_line[1][w] = '0;
        end
        m_u = '0;
    endtask

    task automatic push_ar(input int id, input logic [31:0] a);
        ar_t e;
        e.id   = 2'(id);
        e.addr = (id == 2) ? a : (a & ~32'(LW * 4 - 1));
        e.len  = (id == 2) ? 4'd0 : 4'(LW - 1);
        exp_ar.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_refresh"}, {icache_refresh, dcache_refresh, uc_refresh}, 0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_arid"}, arid, 0);
        chk({tag, "_arlen"}, arlen, 0);
        chk({tag, "_icache_line"}, icache_line, 0);
        chk({tag, "_dcache_line"}, dcache_line, 0);
        chk({tag, "_uc_rdata"}, uc_rdata, 0);
    endtask

    // AXI slave: random arready delay, random rvalid gaps, beat data feeds the model.
    initial begin : slave
        int wait_c;
        int total;
        bit ar_active;
        logic [39:0] ar_hold;
        ar_t cur;
        arready = 0; rvalid = 0; rlast = 0; rdata = 0; rid = 0;
        ar_active = 0; wait_c = 0; total = 0; cur = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                sl_ph = 0; sl_beat = 0; ar_active = 0;
                arready = 0; rvalid = 0; rlast = 0;
            end else if (sl_ph == 0) begin
                rvalid = 0; rlast = 0;
                if (arvalid) begin
                    if (!ar_active) begin
                        ar_active = 1;
                        wait_c = (ar_wait_fix >= 0) ? ar_wait_fix : int'($urandom_range(0, 3));
                        ar_hold = {arid, arlen, araddr};
                    end else begin
                        chk("ar_stable", {arid, arlen, araddr}, ar_hold);
                    end
                    if (wait_c == 0) begin
                        arready = 1;
                        ar_active = 0;
                        chk("rready_low_in_ar", rready, 0);
                        if (exp_ar.size() == 0) begin
                            chk("unexpected_ar_id", arid, 4'hF);
                            cur = '0;
                        end else begin
                            cur = exp_ar.pop_front();
                            chk("arid", arid, {2'b00, cur.id});
                            chk("araddr", araddr, cur.addr);
                            chk("arlen", arlen, cur.len);
                            chk("arsize", arsize, 3'b010);
                            chk("arburst", arburst, 2'b01);
                        end
                        if (cur.id == 2'd2) total = 1;
                        else if (seq_data) total = LW;
                        else begin
                            case ($urandom_range(0, 5))
                                0:       total = 3;       // early rlast
                                1:       total = LW + 3;  // counter wrap
                                default: total = LW;
                            endcase
                        end
                        sl_ph = 1; sl_beat = 0;
                    end else begin
                        arready = 0;
                        wait_c--;
                    end
                end else begin
                    arready = 0;
                end
            end else begin
                arready = 0;
                if (rready && ($urandom_range(0, 1) == 1)) begin
                    rvalid = 1;
                    rid    = 4'($urandom);
                    if (seq_data) rdata = (cur.id == 2'd2) ? 32'hDEADBEEF : 32'h100 + 32'(sl_beat);
                    else rdata = $urandom;
                    rlast = (sl_beat == total - 1);
                    if (cur.id == 2'd2) m_u = rdata;
                    else m_line[cur.id][sl_beat % LW] = rdata;
                    sl_beat++;
                    if (rlast) begin
                        ref_t r;
                        r.id = cur.id;
                        r.cyc = cyc + 1;
                        exp_ref.push_back(r);
                        sl_ph = 0;
                    end
                end else begin
                    rvalid = 0; rlast = 0;
                end
            end
        end
    end

    // Monitor: every refresh pulse must match the next expected completion.
    initial begin : monitor
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                chk("ar_r_exclusive", arvalid & rready, 0);
                for (int id = 0; id < 3; id++) begin
                    logic rf;
                    rf = (id == 0) ? icache_refresh : (id == 1) ? dcache_refresh : uc_refresh;
                    if (rf) begin
                        if (exp_ref.size() == 0) begin
                            chk("unexpected_refresh_id", 32'(id), 32'hFFFF);
                        end else begin
                            ref_t e;
                            e = exp_ref.pop_front();
                            chk("refresh_id", 32'(id), 32'(e.id));
                            chk("refresh_cycle", 32'(cyc), 32'(e.cyc));
                            chk("icache_line", icache_line, model_line(0));
                            chk("dcache_line", dcache_line, model_line(1));
                            chk("uc_rdata", uc_rdata, m_u);
                        end
                    end
                end
            end
        end
    end

    // init_m/late_m bits: 0 icache, 1 dcache, 2 uncache. Late requests arrive mid-burst.
    task automatic run_phase(input logic [2:0] init_m, input logic [2:0] late_m,
                             input logic [31:0] ai, input logic [31:0] ad, input logic [31:0] au);
        int prio[3];
        logic [31:0] a[3];
        logic [2:0] rem, pend;
        int first, t;
        bit late_done;
        prio[0] = 1; prio[1] = 2; prio[2] = 0;
        a[0] = ai; a[1] = ad; a[2] = au;
        first = -1;
        for (int k = 0; k < 3; k++)
            if (first < 0 && init_m[prio[k]]) first = prio[k];
        push_ar(first, a[first]);
        rem = init_m | late_m;
        rem[first] = 1'b0;
        for (int k = 0; k < 3; k++)
            if (rem[prio[k]]) push_ar(prio[k], a[prio[k]]);
        @(negedge aclk);
        icache_raddr = ai; dcache_raddr = ad; uc_raddr = au;
        icache_ren = init_m[0]; dcache_ren = init_m[1]; uc_ren = init_m[2];
        late_done = (late_m == 0);
        pend = init_m | late_m;
        t = 0;
        while ((pend != 0 || !late_done) && t < 3000) begin
            @(negedge aclk);
            t++;
            if (icache_refresh) begin icache_ren = 0; pend[0] = 0; end
            if (dcache_refresh) begin dcache_ren = 0; pend[1] = 0; end
            if (uc_refresh)     begin uc_ren = 0;     pend[2] = 0; end
            if (!late_done && rready) begin
                if (late_m[0]) icache_ren = 1;
                if (late_m[1]) dcache_ren = 1;
                if (late_m[2]) uc_ren = 1;
                late_done = 1;
            end
        end
        chk("phase_in_time", (t < 3000), 1);
        icache_ren = 0; dcache_ren = 0; uc_ren = 0;
        repeat (3) @(negedge aclk);
        chk("ar_queue_drained", exp_ar.size(), 0);
        chk("ref_queue_drained", exp_ref.size(), 0);
        exp_ar.delete();
        exp_ref.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t;
        aresetn = 0;
        icache_ren = 0; dcache_ren = 0; uc_ren = 0;
        icache_raddr = 0; dcache_raddr = 0; uc_raddr = 0;
        clear_model();
        #3;
        check_zero("reset");
        repeat (2) @(negedge aclk);
        aresetn = 1;

        // Directed: icache refill, three-way contention, uncached read, slow arready.
        seq_data = 1; ar_wait_fix = 0;
        run_phase(3'b001, 3'b000, 32'h1FC0_0014, 32'h0, 32'h0);
        seq_data = 0; ar_wait_fix = -1;
        run_phase(3'b111, 3'b000, 32'h0000_1040, 32'h0000_2080, 32'hBFAF_0010);
        seq_data = 1;
        run_phase(3'b100, 3'b000, 32'h0, 32'h0, 32'hBFAF_8004);
        seq_data = 0; ar_wait_fix = 5;
        run_phase(3'b010, 3'b000, 32'h0, 32'h8000_03FC, 32'h0);
        ar_wait_fix = -1;

        for (int p = 0; p < 30; p++) begin
            logic [2:0] im, lm;
            im = 3'($urandom_range(1, 7));
            lm = 3'($urandom_range(0, 7)) & ~im;
            run_phase(im, lm, $urandom, $urandom, $urandom);
        end

        // Reset in the middle of the third beat of an icache burst.
        seq_data = 1;
        @(negedge aclk);
        icache_raddr = 32'h0000_1234;
        icache_ren = 1;
        push_ar(0, 32'h0000_1234);
        t = 0;
        while (!(sl_ph == 1 && sl_beat == 3) && t < 500) begin
            @(negedge aclk);
            #1;
            t++;
        end
        chk("reached_third_beat", (t < 500), 1);
        #1 aresetn = 0;
        #1 check_zero("mid_burst_reset");
        icache_ren = 0;
        repeat (2) @(negedge aclk);
        exp_ar.delete();
        exp_ref.delete();
        clear_model();
        @(negedge aclk);
        aresetn = 1;
        seq_data = 0;
        run_phase(3'b001, 3'b000, 32'h8000_0044, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
